// File: rtl/lab1_button_conditioner_if.sv
// Button-to-ALU select bundle: raw pushbuttons in, ALU selects and mode statistics out.
interface lab1_button_conditioner_if;
    logic       left_btn_raw;
    logic       right_btn_raw;
    logic       LEFT_pushbutton;
    logic       RIGHT_pushbutton;
    logic       op_changed;
    logic [7:0] mode_changes;

    // Board/stimulus side: drives the buttons, watches the selects.
    modport master (
        output left_btn_raw, right_btn_raw,
        input  LEFT_pushbutton, RIGHT_pushbutton, op_changed, mode_changes
    );

    // Conditioner side.
    modport slave (
        input  left_btn_raw, right_btn_raw,
        output LEFT_pushbutton, RIGHT_pushbutton, op_changed, mode_changes
    );
endinterface

// File: rtl/lab1_button_conditioner.sv
// Pushbutton conditioner for the lab1 AND/ADD ALU: synchronise, debounce and
// edge-detect two raw buttons, then latch the last requested operation.

// One button lane: 2-flop synchroniser, counter debouncer, rising-edge press pulse.
module lab1_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic [1:0]       sync;
    logic             stable;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then only accept a new level after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync        <= '0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
        end else begin
            sync        <= {sync[0], raw};
            stable_prev <= stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Press is the debounced rising edge only; releases are silent.
    assign press = stable & ~stable_prev;
endmodule

module lab1_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    lab1_button_conditioner_if.slave   btn_if
);
    localparam int NUM_BTN = 2;  // lane 0 = left (AND), lane 1 = right (ADD)

    typedef enum logic [1:0] {ST_NONE, ST_AND, ST_ADD} state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    state_t             state, state_nxt;
    logic               changed;
    logic               op_changed_q;
    logic [7:0]         mode_cnt;

    assign raw = {btn_if.right_btn_raw, btn_if.left_btn_raw};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        lab1_btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[g]),
            .press (press[g])
        );
    end

    // Next mode: a single press selects its op; simultaneous presses are ambiguous and ignored.
    always_comb begin
        state_nxt = state;
        if (press[0] && !press[1])
            state_nxt = ST_AND;
        else if (press[1] && !press[0])
            state_nxt = ST_ADD;
        changed = (state_nxt != state);
    end

    // Mode register plus change pulse and saturating change counter, all updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_NONE;
            op_changed_q <= 1'b0;
            mode_cnt     <= 8'd0;
        end else begin
            state        <= state_nxt;
            op_changed_q <= changed;
            if (changed && mode_cnt != 8'hFF)
                mode_cnt <= mode_cnt + 8'd1;
        end
    end

    assign btn_if.LEFT_pushbutton  = (state == ST_AND);
    assign btn_if.RIGHT_pushbutton = (state == ST_ADD);
    assign btn_if.op_changed       = op_changed_q;
    assign btn_if.mode_changes     = mode_cnt;
endmodule

// File: tb/tb_lab1_button_conditioner.sv
// Self-checking bench for lab1_button_conditioner with a short debounce window.
module tb_lab1_button_conditioner;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lab1_button_conditioner_if bif();

    lab1_button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_if (bif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a button's accepted level follows its raw input, seen two
    // clocks late, once the raw level has disagreed with it for D samples in a row.
    // A fresh accepted "pushed" level requests that button's op one clock later.
    int m_hist[2][2];
    int m_level[2];
    int m_run[2];
    bit m_req[2];
    int m_mode;      // 0 none, 1 AND, 2 ADD
    bit m_op;
    int m_cnt;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_hist[b][0] = 0; m_hist[b][1] = 0;
            m_level[b] = 0; m_run[b] = 0; m_req[b] = 0;
        end
        m_mode = 0; m_op = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int want;
        int seen;
        int rawv[2];
        want = m_mode;
        if (m_req[0] && !m_req[1]) want = 1;
        if (m_req[1] && !m_req[0]) want = 2;
        m_op = (want != m_mode);
        if (m_op && m_cnt < 255) m_cnt++;
        m_mode = want;
        rawv[0] = int'(bif.left_btn_raw);
        rawv[1] = int'(bif.right_btn_raw);
        for (int b = 0; b < 2; b++) begin
            m_req[b] = 0;
            seen = m_hist[b][1];
            m_hist[b][1] = m_hist[b][0];
            m_hist[b][0] = rawv[b];
            if (seen != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_level[b] = seen;
                    m_run[b] = 0;
                    m_req[b] = (seen == 1);
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    // One clock: edge, model update, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [3:0] alu(input logic l, input logic r, input logic [3:0] a, input logic [3:0] b);
        if (l) return a & b;
        if (r) return a + b;
        return 4'd0;
    endfunction

    task automatic test_reset();
        bif.left_btn_raw = 0; bif.right_btn_raw = 0;
        @(negedge clk); @(negedge clk);
        rst = 1; #1;
        total++;
        if ({bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes} !== 11'd0) begin
            bad++; $display("FAIL reset_async: got %b/%b/%b/%0d want 0/0/0/0", bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes);
        end
        model_reset();
        @(negedge clk); rst = 0;
        repeat (3) step();
        total++;
        if ({bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes} !== 11'd0) begin
            bad++; $display("FAIL reset_release: got %b/%b/%b/%0d want 0/0/0/0", bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes);
        end
    endtask

    task automatic test_clean_press();
        bif.left_btn_raw = 1;
        repeat (6) step();
        total++;
        if (bif.LEFT_pushbutton !== 1'b0 || bif.op_changed !== 1'b0) begin
            bad++; $display("FAIL press_early: got L=%b op=%b want 0 0 after edge k+5", bif.LEFT_pushbutton, bif.op_changed);
        end
        step();
        total++;
        if (bif.LEFT_pushbutton !== 1'b1 || bif.RIGHT_pushbutton !== 1'b0 || bif.op_changed !== 1'b1 || bif.mode_changes !== 8'd1) begin
            bad++; $display("FAIL press_k6: got L=%b R=%b op=%b cnt=%0d want 1 0 1 1", bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes);
        end
        step();
        total++;
        if (bif.op_changed !== 1'b0 || bif.mode_changes !== 8'd1) begin
            bad++; $display("FAIL press_k7: got op=%b cnt=%0d want 0 1", bif.op_changed, bif.mode_changes);
        end
        bif.left_btn_raw = 0;
        repeat (8) step();
        total++;
        if (bif.LEFT_pushbutton !== 1'b1 || bif.op_changed !== 1'b0) begin
            bad++; $display("FAIL press_release_hold: got L=%b op=%b want 1 0", bif.LEFT_pushbutton, bif.op_changed);
        end
    endtask

    task automatic test_bounce();
        int early;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            bif.right_btn_raw = (i % 2 == 0);
            repeat (2) begin
                step();
                if (bif.op_changed !== 1'b0 || bif.RIGHT_pushbutton !== 1'b0) early++;
            end
        end
        bif.right_btn_raw = 1;
        repeat (6) begin
            step();
            if (bif.op_changed !== 1'b0 || bif.RIGHT_pushbutton !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL bounce_quiet: got %0d early change cycles want 0", early);
        end
        step();
        total++;
        if (bif.RIGHT_pushbutton !== 1'b1 || bif.LEFT_pushbutton !== 1'b0 || bif.op_changed !== 1'b1 || bif.mode_changes !== 8'd2) begin
            bad++; $display("FAIL bounce_settle: got L=%b R=%b op=%b cnt=%0d want 0 1 1 2", bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes);
        end
        step();
        total++;
        if (bif.op_changed !== 1'b0) begin
            bad++; $display("FAIL bounce_single_pulse: got op=%b want 0", bif.op_changed);
        end
        bif.right_btn_raw = 0;
        repeat (8) step();
    endtask

    task automatic test_ambiguous();
        int pulses;
        pulses = 0;
        bif.left_btn_raw = 1; bif.right_btn_raw = 1;
        repeat (10) begin
            step();
            if (bif.op_changed !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0 || bif.RIGHT_pushbutton !== 1'b1 || bif.LEFT_pushbutton !== 1'b0) begin
            bad++; $display("FAIL both_pressed: got pulses=%0d L=%b R=%b want 0 0 1", pulses, bif.LEFT_pushbutton, bif.RIGHT_pushbutton);
        end
        bif.left_btn_raw = 0; bif.right_btn_raw = 0;
        repeat (8) step();
        pulses = 0;
        bif.right_btn_raw = 1;
        repeat (10) begin
            step();
            if (bif.op_changed !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0 || bif.mode_changes !== 8'd2 || bif.RIGHT_pushbutton !== 1'b1) begin
            bad++; $display("FAIL redundant_press: got pulses=%0d cnt=%0d R=%b want 0 2 1", pulses, bif.mode_changes, bif.RIGHT_pushbutton);
        end
        bif.right_btn_raw = 0;
        repeat (8) step();
    endtask

    task automatic test_reset_mid();
        bif.left_btn_raw = 1;
        repeat (3) step();
        rst = 1; #1;
        total++;
        if ({bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes} !== 11'd0) begin
            bad++; $display("FAIL reset_mid_clear: got %b/%b/%b/%0d want 0/0/0/0", bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes);
        end
        model_reset();
        @(negedge clk); rst = 0;
        repeat (6) step();
        total++;
        if (bif.LEFT_pushbutton !== 1'b0) begin
            bad++; $display("FAIL reset_mid_redebounce_early: got L=%b want 0", bif.LEFT_pushbutton);
        end
        step();
        total++;
        if (bif.LEFT_pushbutton !== 1'b1 || bif.op_changed !== 1'b1 || bif.mode_changes !== 8'd1) begin
            bad++; $display("FAIL reset_mid_redebounce: got L=%b op=%b cnt=%0d want 1 1 1", bif.LEFT_pushbutton, bif.op_changed, bif.mode_changes);
        end
        bif.left_btn_raw = 0;
        repeat (8) step();
    endtask

    task automatic test_saturation_alu();
        bit       last_pulse;
        int       miss;
        logic [3:0] res;
        miss = 0;
        for (int i = 0; i < 260; i++) begin
            last_pulse = 0;
            if (i % 2 == 0) bif.right_btn_raw = 1; else bif.left_btn_raw = 1;
            repeat (7) begin
                step();
                if (bif.op_changed === 1'b1) last_pulse = 1;
                if (bif.mode_changes !== 8'(m_cnt) || bif.op_changed !== m_op) miss++;
            end
            bif.left_btn_raw = 0; bif.right_btn_raw = 0;
            repeat (7) step();
        end
        total++;
        if (miss != 0) begin
            bad++; $display("FAIL saturation_track: got %0d model disagreements want 0", miss);
        end
        total++;
        if (bif.mode_changes !== 8'd255 || !last_pulse) begin
            bad++; $display("FAIL saturation: got cnt=%0d last_pulse=%b want 255 1", bif.mode_changes, last_pulse);
        end
        res = alu(bif.LEFT_pushbutton, bif.RIGHT_pushbutton, 4'b1100, 4'b1010);
        total++;
        if (res !== 4'b1000) begin
            bad++; $display("FAIL alu_and: got %b want 1000", res);
        end
        bif.right_btn_raw = 1;
        repeat (8) step();
        res = alu(bif.LEFT_pushbutton, bif.RIGHT_pushbutton, 4'b1100, 4'b1010);
        total++;
        if (res !== 4'b0110) begin
            bad++; $display("FAIL alu_add: got %b want 0110", res);
        end
        bif.right_btn_raw = 0;
        repeat (8) step();
    endtask

    task automatic test_random();
        int dur;
        for (int seg = 0; seg < 120; seg++) begin
            bif.left_btn_raw  = $urandom_range(0, 1);
            bif.right_btn_raw = $urandom_range(0, 1);
            dur = $urandom_range(1, 9);
            repeat (dur) begin
                step();
                total++;
                if (bif.LEFT_pushbutton !== (m_mode == 1) || bif.RIGHT_pushbutton !== (m_mode == 2) ||
                    bif.op_changed !== m_op || bif.mode_changes !== 8'(m_cnt)) begin
                    bad++;
                    $display("FAIL random_seg%0d: got L=%b R=%b op=%b cnt=%0d want L=%b R=%b op=%b cnt=%0d",
                             seg, bif.LEFT_pushbutton, bif.RIGHT_pushbutton, bif.op_changed, bif.mode_changes,
                             m_mode == 1, m_mode == 2, m_op, m_cnt);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_ambiguous();
        test_reset_mid();
        test_saturation_alu();
        rst = 1; #1; model_reset();
        @(negedge clk); rst = 0;
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
